// File: rtl/surf_cout_train_pkg.sv
// rtl/surf_cout_train_pkg.sv - shared types and helpers for the COUT auto-trainer
//
// Contents:
//   train_state_e      trainer FSM states
//   NUM_BITSLIP_TRIES  bitslips attempted before alignment is declared failed
//   rotl32             32-bit rotate left
//   rot_match          {hit, index}: word equals pattern rotated left by index*step
package surf_cout_train_pkg;

    localparam int NUM_BITSLIP_TRIES = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT,
        S_EVAL,
        S_CENTER,
        S_LOAD_C,
        S_ALIGN,
        S_BITSLIP,
        S_DONE,
        S_FAIL
    } train_state_e;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int s);
        logic [63:0] dbl;
        dbl = {v, v} << (s % 32);
        return dbl[63:32];
    endfunction

    // Scans downward so the lowest matching rotation index wins.
    function automatic logic [5:0] rot_match(input logic [31:0] pattern,
                                             input logic [31:0] word,
                                             input int          step);
        logic [5:0] r;
        r = '0;
        for (int k = 31; k >= 0; k--) begin
            if (((k * step) < 32) && (word == rotl32(pattern, k * step))) begin
                r = {1'b1, 5'(k)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/surf_cout_eye_tracker.sv
// rtl/surf_cout_eye_tracker.sv - on-the-fly longest passing-run tracker for the tap scan
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             drop all run state (new training pass)
//   strobe            one tap result is presented on tap/pass
//   tap, pass         tap index and its pass/fail verdict
//   end_of_scan       last tap of the sweep; closes the current run
//   best_start        first tap of the widest run seen so far
//   best_len          width of that run in taps
module surf_cout_eye_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       strobe,
    input  logic [5:0] tap,
    input  logic       pass,
    input  logic       end_of_scan,
    output logic [5:0] best_start,
    output logic [6:0] best_len
);

    logic [5:0] cur_start_q, cur_start_d;
    logic [6:0] cur_len_q, cur_len_d;
    logic [5:0] best_start_q, best_start_d;
    logic [6:0] best_len_q, best_len_d;

    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (strobe) begin
            if (pass) begin
                cur_len_d = cur_len_q + 7'd1;
                if (cur_len_q == 7'd0) begin
                    cur_start_d = tap;
                end
                // Strictly greater: an equal-width later run never displaces the earlier one.
                if (cur_len_d > best_len_q) begin
                    best_start_d = cur_start_d;
                    best_len_d   = cur_len_d;
                end
            end else begin
                cur_len_d = '0;
            end
            // Best is already updated above, so closing just forgets the run (no wrap to tap 0).
            if (end_of_scan) begin
                cur_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start = best_start_q;
    assign best_len   = best_len_q;

endmodule

// File: rtl/surf_cout_autotrain.sv
// rtl/surf_cout_autotrain.sv - automatic COUT link trainer (IDELAY eye scan + bitslip alignment)
//
// Sweeps IDELAY taps 0..MAX_TAP, loads the centre of the widest passing eye,
// then bitslips the COUT ISERDES until the capture is a nibble rotation of
// TRAIN_PATTERN.
//
// Ports:
//   sysclk_i, rst_i                          clock, synchronous active-high reset
//   start_i                                  begin training (ignored while busy_o)
//   cout_data_i, cout_valid_i                captured word and its one-cycle valid
//   cout_capture_o                           one-cycle capture request
//   idelay_value_o, idelay_cout_load_o       tap value and one-cycle load strobe
//   iserdes_cout_bitslip_o                   one-cycle bitslip strobe
//   cout_enable_o, busy_o, done_o, fail_o    status
//   eye_start_o, eye_width_o                 chosen eye
//   nibble_offset_o                          rotation k (pattern rotated left by 4k)
//   eye_map_o                                per-tap pass map, only with SURF_COUT_AUTOTRAIN_EYEMAP_EN
//
// Build option: SURF_COUT_AUTOTRAIN_EYEMAP_EN adds eye_map_o and its register.
module surf_cout_autotrain
    import surf_cout_train_pkg::*;
#(
    parameter logic [31:0] TRAIN_PATTERN   = 32'hA55A6996,
    parameter int          MAX_TAP         = 31,
    parameter int          SETTLE_CYCLES   = 16,
    parameter int          SAMPLES_PER_TAP = 4,
    parameter int          MIN_EYE         = 4,
    parameter int          CAPTURE_TIMEOUT = 255
) (
    input  logic        sysclk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] cout_data_i,
    input  logic        cout_valid_i,
    output logic        cout_capture_o,
    output logic [5:0]  idelay_value_o,
    output logic        idelay_cout_load_o,
    output logic        iserdes_cout_bitslip_o,
    output logic        cout_enable_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [5:0]  eye_start_o,
    output logic [6:0]  eye_width_o,
    output logic [2:0]  nibble_offset_o
`ifdef SURF_COUT_AUTOTRAIN_EYEMAP_EN
    ,
    output logic [63:0] eye_map_o
`endif
);

    train_state_e state_q, state_d;
    logic [5:0]   tap_q, tap_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   pass_cnt_q, pass_cnt_d;
    logic [2:0]   slips_q, slips_d;
    logic         align_q, align_d;
    logic         sample_hit_q, sample_hit_d;
    logic [2:0]   sample_idx_q, sample_idx_d;

    logic         capture_q, capture_d;
    logic         load_q, load_d;
    logic         bitslip_q, bitslip_d;
    logic [5:0]   idelay_value_q, idelay_value_d;
    logic         enable_q, enable_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         fail_q, fail_d;
    logic [5:0]   eye_start_q, eye_start_d;
    logic [6:0]   eye_width_q, eye_width_d;
    logic [2:0]   nibble_q, nibble_d;
`ifdef SURF_COUT_AUTOTRAIN_EYEMAP_EN
    logic [63:0]  eye_map_q, eye_map_d;
`endif

    logic         trk_clear, trk_strobe, trk_eos;
    logic [5:0]   best_start;
    logic [6:0]   best_len;

    logic [5:0]   scan_res;
    logic [5:0]   align_res;
    logic [6:0]   center_tap;
    logic         unused_bits;

    // Scan accepts any 1-bit rotation (bit alignment is fixed later by bitslip);
    // alignment needs a whole-nibble rotation.
    assign scan_res    = rot_match(TRAIN_PATTERN, cout_data_i, 1);
    assign align_res   = rot_match(TRAIN_PATTERN, cout_data_i, 4);
    assign center_tap  = {1'b0, best_start} + {1'b0, best_len[6:1]};
    assign unused_bits = ^{scan_res[4:0], align_res[4:3], center_tap[6]};

    surf_cout_eye_tracker u_eye_tracker (
        .clk         (sysclk_i),
        .rst         (rst_i),
        .clear       (trk_clear),
        .strobe      (trk_strobe),
        .tap         (tap_q),
        .pass        (sample_hit_q),
        .end_of_scan (trk_eos),
        .best_start  (best_start),
        .best_len    (best_len)
    );

    always_comb begin
        state_d        = state_q;
        tap_d          = tap_q;
        cnt_d          = cnt_q;
        pass_cnt_d     = pass_cnt_q;
        slips_d        = slips_q;
        align_d        = align_q;
        sample_hit_d   = sample_hit_q;
        sample_idx_d   = sample_idx_q;
        idelay_value_d = idelay_value_q;
        enable_d       = enable_q;
        done_d         = done_q;
        fail_d         = fail_q;
        eye_start_d    = eye_start_q;
        eye_width_d    = eye_width_q;
        nibble_d       = nibble_q;
        trk_clear      = 1'b0;
        trk_strobe     = 1'b0;
        trk_eos        = 1'b0;
`ifdef SURF_COUT_AUTOTRAIN_EYEMAP_EN
        eye_map_d      = eye_map_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    enable_d    = 1'b0;
                    eye_start_d = '0;
                    eye_width_d = '0;
                    nibble_d    = '0;
                    tap_d       = '0;
                    pass_cnt_d  = '0;
                    slips_d     = '0;
                    align_d     = 1'b0;
                    trk_clear   = 1'b1;
`ifdef SURF_COUT_AUTOTRAIN_EYEMAP_EN
                    eye_map_d   = '0;
`endif
                    state_d     = S_LOAD;
                end
            end
            S_LOAD, S_LOAD_C, S_BITSLIP: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cout_valid_i) begin
                    sample_hit_d = align_q ? align_res[5] : scan_res[5];
                    sample_idx_d = align_res[2:0];
                    state_d      = align_q ? S_ALIGN : S_EVAL;
                end else if (cnt_q == 8'(CAPTURE_TIMEOUT - 1)) begin
                    sample_hit_d = 1'b0;
                    state_d      = align_q ? S_ALIGN : S_EVAL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EVAL: begin
                if (sample_hit_q && ((pass_cnt_q + 8'd1) < 8'(SAMPLES_PER_TAP))) begin
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    state_d    = S_CAPTURE;
                end else begin
                    // sample_hit_q here is the tap verdict: a fail ends the tap early,
                    // otherwise all required samples passed.
                    trk_strobe = 1'b1;
                    pass_cnt_d = '0;
`ifdef SURF_COUT_AUTOTRAIN_EYEMAP_EN
                    eye_map_d[tap_q] = sample_hit_q;
`endif
                    if (tap_q == 6'(MAX_TAP)) begin
                        trk_eos = 1'b1;
                        state_d = S_CENTER;
                    end else begin
                        tap_d   = tap_q + 6'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_CENTER: begin
                if (best_len < 7'(MIN_EYE)) begin
                    fail_d  = 1'b1;
                    state_d = S_FAIL;
                end else begin
                    tap_d       = center_tap[5:0];
                    eye_start_d = best_start;
                    eye_width_d = best_len;
                    align_d     = 1'b1;
                    slips_d     = '0;
                    state_d     = S_LOAD_C;
                end
            end
            S_ALIGN: begin
                if (sample_hit_q) begin
                    nibble_d = sample_idx_q;
                    done_d   = 1'b1;
                    enable_d = 1'b1;
                    state_d  = S_DONE;
                end else if (slips_q == 3'(NUM_BITSLIP_TRIES)) begin
                    fail_d  = 1'b1;
                    state_d = S_FAIL;
                end else begin
                    slips_d = slips_q + 3'd1;
                    state_d = S_BITSLIP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state, so each lasts exactly the one
        // cycle spent in its state and no two can coincide.
        load_d    = (state_d == S_LOAD) || (state_d == S_LOAD_C);
        capture_d = (state_d == S_CAPTURE);
        bitslip_d = (state_d == S_BITSLIP);
        busy_d    = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FAIL));
        if (load_d) begin
            idelay_value_d = tap_d;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            tap_q          <= '0;
            cnt_q          <= '0;
            pass_cnt_q     <= '0;
            slips_q        <= '0;
            align_q        <= 1'b0;
            sample_hit_q   <= 1'b0;
            sample_idx_q   <= '0;
            capture_q      <= 1'b0;
            load_q         <= 1'b0;
            bitslip_q      <= 1'b0;
            idelay_value_q <= '0;
            enable_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
            eye_start_q    <= '0;
            eye_width_q    <= '0;
            nibble_q       <= '0;
`ifdef SURF_COUT_AUTOTRAIN_EYEMAP_EN
            eye_map_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            cnt_q          <= cnt_d;
            pass_cnt_q     <= pass_cnt_d;
            slips_q        <= slips_d;
            align_q        <= align_d;
            sample_hit_q   <= sample_hit_d;
            sample_idx_q   <= sample_idx_d;
            capture_q      <= capture_d;
            load_q         <= load_d;
            bitslip_q      <= bitslip_d;
            idelay_value_q <= idelay_value_d;
            enable_q       <= enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            fail_q         <= fail_d;
            eye_start_q    <= eye_start_d;
            eye_width_q    <= eye_width_d;
            nibble_q       <= nibble_d;
`ifdef SURF_COUT_AUTOTRAIN_EYEMAP_EN
            eye_map_q      <= eye_map_d;
`endif
        end
    end

    assign cout_capture_o         = capture_q;
    assign idelay_value_o         = idelay_value_q;
    assign idelay_cout_load_o     = load_q;
    assign iserdes_cout_bitslip_o = bitslip_q;
    assign cout_enable_o          = enable_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign fail_o                 = fail_q;
    assign eye_start_o            = eye_start_q;
    assign eye_width_o            = eye_width_q;
    assign nibble_offset_o        = nibble_q;
`ifdef SURF_COUT_AUTOTRAIN_EYEMAP_EN
    assign eye_map_o              = eye_map_q;
`endif

endmodule
